// File: rtl/op_pkt_pkg.sv
// Shared definitions for the op packet checker: packet layout, drop codes, default limits.
package op_pkt_pkg;
  localparam int DATA_WIDTH_D = 32;
  localparam int RES_WIDTH_D  = 4;
  localparam int NUM_MODES_D  = 4;
  localparam int RES_MIN_D    = 6;

  // Packet layout: {res, mode, data}, res in the MSBs.
  localparam int PKT_W    = RES_WIDTH_D + NUM_MODES_D + DATA_WIDTH_D;
  localparam int MODE_LSB = DATA_WIDTH_D;
  localparam int RES_LSB  = DATA_WIDTH_D + NUM_MODES_D;

  typedef enum logic [1:0] {
    DROP_NONE = 2'b00,
    DROP_MODE = 2'b01,
    DROP_RES  = 2'b10,
    DROP_PAR  = 2'b11
  } drop_reason_e;
endpackage

// File: rtl/op_pkt_fifo.sv
// Synchronous show-ahead FIFO: the head entry is presented on rdata whenever not empty.
module op_pkt_fifo #(
  parameter int WIDTH = 40,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  logic [WIDTH-1:0]         wdata,
  input  logic                     pop,
  output logic [WIDTH-1:0]         rdata,
  output logic [$clog2(DEPTH):0]   level,
  output logic                     full,
  output logic                     empty
);
  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wptr, rptr;
  logic [AW:0]      count;
  logic             do_push, do_pop;

  assign full    = (count == (AW+1)'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign level   = count;
  assign rdata   = empty ? '0 : mem[rptr];

  // DEPTH is a power of two, so the pointers wrap by natural overflow.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else begin
      if (do_push) wptr <= wptr + 1'b1;
      if (do_pop)  rptr <= rptr + 1'b1;
      if (do_push && !do_pop)      count <= count + 1'b1;
      else if (do_pop && !do_push) count <= count - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wptr] <= wdata;
  end
endmodule

// File: rtl/op_pkt_chk_q.sv
// Packet checker: validates mode/res, queues good packets, strobes drop reasons, keeps statistics.
// Optional OP_PKT_CHK_PARITY_EN adds in_par (even parity over in_pkt) and drop_par_cnt.
module op_pkt_chk_q
  import op_pkt_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int RES_WIDTH  = 4,
  parameter int NUM_MODES  = 4,
  parameter int RES_MIN    = RES_MIN_D,
  parameter int DEPTH      = 4,
  parameter int CNT_WIDTH  = 16,
  localparam int PW        = RES_WIDTH + NUM_MODES + DATA_WIDTH
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [PW-1:0]          in_pkt,
`ifdef OP_PKT_CHK_PARITY_EN
  input  logic                   in_par,
  output logic [CNT_WIDTH-1:0]   drop_par_cnt,
`endif
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [PW-1:0]          out_pkt,
  output logic                   drop_pulse,
  output logic [1:0]             drop_reason,
  input  logic                   cnt_clr,
  output logic [CNT_WIDTH-1:0]   good_cnt,
  output logic [CNT_WIDTH-1:0]   drop_mode_cnt,
  output logic [CNT_WIDTH-1:0]   drop_res_cnt,
  output logic [$clog2(DEPTH):0] fifo_level
);
  // Handshake: a beat transfers on a rising edge where valid && ready; ready never depends
  // combinationally on the same-cycle valid or on out_ready.
  logic [RES_WIDTH-1:0] res;
  logic [NUM_MODES-1:0] mode;
  logic                 mode_ok, res_ok, par_ok, accept, push, pop, full, empty;
  drop_reason_e         reason;

  assign res     = in_pkt[PW-1 -: RES_WIDTH];
  assign mode    = in_pkt[DATA_WIDTH +: NUM_MODES];
  assign mode_ok = (mode != '0) && ((mode & (mode - 1'b1)) == '0);
  assign res_ok  = ({1'b0, res} >= (RES_WIDTH+1)'(RES_MIN));
`ifdef OP_PKT_CHK_PARITY_EN
  assign par_ok  = ~(^{in_pkt, in_par});
`else
  assign par_ok  = 1'b1;
`endif

  always_comb begin
    reason = DROP_NONE;
    if (!par_ok)       reason = DROP_PAR;
    else if (!mode_ok) reason = DROP_MODE;
    else if (!res_ok)  reason = DROP_RES;
  end

  // in_ready is gated by rst_n so it reads 0 throughout reset.
  assign in_ready  = rst_n && !full;
  assign accept    = in_valid && in_ready;
  assign push      = accept && (reason == DROP_NONE);
  assign out_valid = !empty;
  assign pop       = out_valid && out_ready;

  op_pkt_fifo #(.WIDTH(PW), .DEPTH(DEPTH)) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (push),
    .wdata (in_pkt),
    .pop   (pop),
    .rdata (out_pkt),
    .level (fifo_level),
    .full  (full),
    .empty (empty)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      drop_pulse  <= 1'b0;
      drop_reason <= DROP_NONE;
    end else begin
      drop_pulse  <= accept && (reason != DROP_NONE);
      drop_reason <= accept ? reason : DROP_NONE;
    end
  end

  // Saturating statistics; a clear wins over a same-cycle increment.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      good_cnt      <= '0;
      drop_mode_cnt <= '0;
      drop_res_cnt  <= '0;
`ifdef OP_PKT_CHK_PARITY_EN
      drop_par_cnt  <= '0;
`endif
    end else if (cnt_clr) begin
      good_cnt      <= '0;
      drop_mode_cnt <= '0;
      drop_res_cnt  <= '0;
`ifdef OP_PKT_CHK_PARITY_EN
      drop_par_cnt  <= '0;
`endif
    end else begin
      if (push && good_cnt != '1) good_cnt <= good_cnt + 1'b1;
      if (accept && reason == DROP_MODE && drop_mode_cnt != '1)
        drop_mode_cnt <= drop_mode_cnt + 1'b1;
      if (accept && reason == DROP_RES && drop_res_cnt != '1)
        drop_res_cnt <= drop_res_cnt + 1'b1;
`ifdef OP_PKT_CHK_PARITY_EN
      if (accept && reason == DROP_PAR && drop_par_cnt != '1)
        drop_par_cnt <= drop_par_cnt + 1'b1;
`endif
    end
  end
endmodule

// File: tb/tb_op_pkt_chk_q.sv
// Directed bench for op_pkt_chk_q: default instance plus a CNT_WIDTH=2 instance for saturation.
module tb_op_pkt_chk_q;
  localparam int PW = 40;

  logic          clk, rst_n, in_valid, out_ready, cnt_clr;
  logic [PW-1:0] in_pkt;
  logic          in_ready, out_valid, drop_pulse;
  logic [PW-1:0] out_pkt;
  logic [1:0]    drop_reason;
  logic [15:0]   good_cnt, drop_mode_cnt, drop_res_cnt;
  logic [2:0]    fifo_level;
  logic          s_in_ready, s_out_valid, s_drop_pulse;
  logic [PW-1:0] s_out_pkt;
  logic [1:0]    s_drop_reason, s_good_cnt, s_drop_mode_cnt, s_drop_res_cnt;
  logic [2:0]    s_fifo_level;
`ifdef OP_PKT_CHK_PARITY_EN
  logic          in_par;
  logic [15:0]   drop_par_cnt;
  logic [1:0]    s_drop_par_cnt;
`endif

  int test_cnt = 0;
  int fail_cnt = 0;
  logic [PW-1:0] p [5];

  op_pkt_chk_q dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .in_pkt(in_pkt),
`ifdef OP_PKT_CHK_PARITY_EN
    .in_par(in_par), .drop_par_cnt(drop_par_cnt),
`endif
    .out_valid(out_valid), .out_ready(out_ready), .out_pkt(out_pkt),
    .drop_pulse(drop_pulse), .drop_reason(drop_reason), .cnt_clr(cnt_clr),
    .good_cnt(good_cnt), .drop_mode_cnt(drop_mode_cnt), .drop_res_cnt(drop_res_cnt),
    .fifo_level(fifo_level)
  );

  op_pkt_chk_q #(.CNT_WIDTH(2)) dut_sat (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(s_in_ready), .in_pkt(in_pkt),
`ifdef OP_PKT_CHK_PARITY_EN
    .in_par(in_par), .drop_par_cnt(s_drop_par_cnt),
`endif
    .out_valid(s_out_valid), .out_ready(out_ready), .out_pkt(s_out_pkt),
    .drop_pulse(s_drop_pulse), .drop_reason(s_drop_reason), .cnt_clr(cnt_clr),
    .good_cnt(s_good_cnt), .drop_mode_cnt(s_drop_mode_cnt), .drop_res_cnt(s_drop_res_cnt),
    .fifo_level(s_fifo_level)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic logic [PW-1:0] mk(input logic [3:0] r, input logic [3:0] m,
                                       input logic [31:0] d);
    return {r, m, d};
  endfunction

  task automatic drive(input logic v, input logic [PW-1:0] pk);
    in_valid = v;
    in_pkt   = pk;
`ifdef OP_PKT_CHK_PARITY_EN
    in_par   = ^pk;
`endif
  endtask

  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    test_cnt++;
    assert (obs === exp) else begin
      fail_cnt++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  initial begin
    rst_n = 1'b0; out_ready = 1'b0; cnt_clr = 1'b0;
    drive(1'b0, '0);
    #1;
    chk("rst_in_ready", 64'(in_ready), 0);
    chk("rst_out_valid", 64'(out_valid), 0);
    chk("rst_out_pkt", 64'(out_pkt), 0);
    chk("rst_level", 64'(fifo_level), 0);
    chk("rst_drop_pulse", 64'(drop_pulse), 0);
    chk("rst_good_cnt", 64'(good_cnt), 0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    #1 chk("rel_in_ready", 64'(in_ready), 1);

    // Single good packet, one-cycle latency.
    out_ready = 1'b1;
    drive(1'b1, mk(4'd6, 4'b0100, 32'hDEADBEEF));
    cycle();
    drive(1'b0, '0);
    chk("t1_out_valid", 64'(out_valid), 1);
    chk("t1_out_pkt", 64'(out_pkt), 64'(mk(4'd6, 4'b0100, 32'hDEADBEEF)));
    chk("t1_good_cnt", 64'(good_cnt), 1);
    cycle();
    chk("t1_popped", 64'(out_valid), 0);

    // Mode failures: all-zero and multi-bit.
    drive(1'b1, mk(4'd9, 4'b0000, 32'h1));
    cycle();
    chk("t2_pulse_a", 64'(drop_pulse), 1);
    chk("t2_reason_a", 64'(drop_reason), 1);
    drive(1'b1, mk(4'd9, 4'b0110, 32'h2));
    cycle();
    drive(1'b0, '0);
    chk("t2_pulse_b", 64'(drop_pulse), 1);
    chk("t2_reason_b", 64'(drop_reason), 1);
    chk("t2_mode_cnt", 64'(drop_mode_cnt), 2);
    chk("t2_no_out", 64'(out_valid), 0);
    cycle();
    chk("t2_pulse_off", 64'(drop_pulse), 0);
    chk("t2_reason_off", 64'(drop_reason), 0);

    // Res failure, then a double failure that counts as mode only.
    drive(1'b1, mk(4'd5, 4'b0001, 32'h3));
    cycle();
    chk("t3_reason_res", 64'(drop_reason), 2);
    chk("t3_res_cnt", 64'(drop_res_cnt), 1);
    drive(1'b1, mk(4'd0, 4'b0011, 32'h4));
    cycle();
    drive(1'b0, '0);
    chk("t3_reason_both", 64'(drop_reason), 1);
    chk("t3_res_cnt_hold", 64'(drop_res_cnt), 1);
    chk("t3_mode_cnt", 64'(drop_mode_cnt), 3);
    cycle();

    // Fill to full, stall the fifth, then drain in order.
    out_ready = 1'b0;
    for (int i = 0; i < 5; i++) p[i] = mk(4'd8, 4'(1 << (i % 4)), 32'h1000 + 32'(i));
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, p[i]);
      cycle();
    end
    chk("t4_level_full", 64'(fifo_level), 4);
    chk("t4_in_ready_low", 64'(in_ready), 0);
    chk("t4_head", 64'(out_pkt), 64'(p[0]));
    drive(1'b1, p[4]);
    cycle();
    chk("t4_stalled", 64'(fifo_level), 4);
    chk("t4_head_hold", 64'(out_pkt), 64'(p[0]));
    out_ready = 1'b1;
    cycle();
    chk("t4_pop_level", 64'(fifo_level), 3);
    chk("t4_pop_ready", 64'(in_ready), 1);
    chk("t4_head1", 64'(out_pkt), 64'(p[1]));
    cycle();
    drive(1'b0, '0);
    chk("t4_pushpop_level", 64'(fifo_level), 3);
    chk("t4_head2", 64'(out_pkt), 64'(p[2]));
    cycle();
    chk("t4_head3", 64'(out_pkt), 64'(p[3]));
    cycle();
    chk("t4_head4", 64'(out_pkt), 64'(p[4]));
    cycle();
    chk("t4_empty", 64'(out_valid), 0);
    chk("t4_empty_pkt", 64'(out_pkt), 0);
    chk("t4_good_cnt", 64'(good_cnt), 6);
    chk("sat_good_cnt", 64'(s_good_cnt), 3);
    chk("sat_mode_cnt", 64'(s_drop_mode_cnt), 3);

    // Clear beats a same-cycle increment.
    drive(1'b1, mk(4'd15, 4'b1000, 32'h55));
    cnt_clr = 1'b1;
    cycle();
    drive(1'b0, '0);
    cnt_clr = 1'b0;
    chk("clr_good_cnt", 64'(good_cnt), 0);
    chk("clr_sat_good_cnt", 64'(s_good_cnt), 0);
    chk("clr_mode_cnt", 64'(drop_mode_cnt), 0);
    cycle();
    chk("clr_good_stays", 64'(good_cnt), 0);

    // Asynchronous reset with packets queued.
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, p[i]);
      cycle();
    end
    drive(1'b0, '0);
    chk("ar_level_pre", 64'(fifo_level), 3);
    chk("ar_good_pre", 64'(good_cnt), 3);
    #2 rst_n = 1'b0;
    #1;
    chk("ar_out_valid", 64'(out_valid), 0);
    chk("ar_level", 64'(fifo_level), 0);
    chk("ar_good_cnt", 64'(good_cnt), 0);
    chk("ar_in_ready", 64'(in_ready), 0);
    cycle();
    rst_n = 1'b1;
    cycle();

`ifdef OP_PKT_CHK_PARITY_EN
    in_valid = 1'b1;
    in_pkt   = mk(4'd7, 4'b0010, 32'hCAFE);
    in_par   = ~(^in_pkt);
    cycle();
    drive(1'b0, '0);
    chk("par_reason", 64'(drop_reason), 3);
    chk("par_cnt", 64'(drop_par_cnt), 1);
    chk("par_no_out", 64'(out_valid), 0);
    cycle();
`endif

    $display("[TB] %0d tests run, %0d failed", test_cnt, fail_cnt);
    $finish;
  end
endmodule

// File: doc/op_pkt_chk_q.md
Name: op_pkt_chk_q

Overview:
- Parametrised, flow-controlled packet checker for the op packet path.
- Accepts {res, mode, data} packets over a valid/ready handshake and validates mode (strictly one-hot) and res (>= RES_MIN).
- Good packets are buffered in an internal show-ahead FIFO; bad packets are dropped with a coded reason.
- Keeps saturating good/drop statistics for the CSR block.

Parameters:
- DATA_WIDTH, 32, payload width.
- RES_WIDTH, 4, res field width.
- NUM_MODES, 4, mode field width (one bit per mode).
- RES_MIN, 6, minimum legal res value, inclusive.
- DEPTH, 4, output FIFO entries; power of 2, >= 2.
- CNT_WIDTH, 16, statistics counter width.

Ports:
- clk  in  1  clock.
- rst_n  in  1  reset, asynchronous, active-low.
- in_valid  in  1  input packet valid.
- in_ready  out  1  input may be accepted this cycle.
- in_pkt  in  PKT_W  packet; PKT_W = RES_WIDTH+NUM_MODES+DATA_WIDTH; res in MSBs, mode in the middle, data in LSBs.
- out_valid  out  1  FIFO head valid.
- out_ready  in  1  downstream accepts head.
- out_pkt  out  PKT_W  FIFO head packet.
- drop_pulse  out  1  one-cycle strobe per dropped packet.
- drop_reason  out  2  01 = bad mode, 10 = bad res, 11 = parity (feature only), 00 = none.
- cnt_clr  in  1  synchronous clear of all counters.
- good_cnt  out  CNT_WIDTH  packets written to the FIFO.
- drop_mode_cnt  out  CNT_WIDTH  mode drops.
- drop_res_cnt  out  CNT_WIDTH  res drops.
- fifo_level  out  $clog2(DEPTH)+1  current occupancy.

Behaviour:
- Reset (asynchronous, active-low): FIFO empty, out_valid=0, out_pkt=0, drop_pulse=0, drop_reason=00, all counters=0, fifo_level=0. in_ready=0 while rst_n is low, 1 after release. A packet in flight at reset is lost and is not counted.
- Acceptance: a packet is accepted when in_valid && in_ready. in_ready = (fifo_level != DEPTH), driven from registered state only, with no combinational path from out_ready. A full FIFO stalls drop-bound packets as well.
- Checks (combinational on in_pkt):
  - mode_ok = exactly one bit set. All-zero fails. Any multi-bit pattern fails.
  - res_ok = res >= RES_MIN, unsigned compare.
- Good packet: written to the FIFO tail on the acceptance edge. good_cnt increments.
- Bad packet: not written. On the next cycle, drop_pulse=1 and drop_reason is set. drop_pulse and drop_reason return to 0/00 the following cycle unless another drop occurs.
- Drop priority: mode failure beats res failure. A packet failing both is counted only in drop_mode_cnt, with reason 01.
- Latency: a good packet accepted at edge N is visible on out_valid/out_pkt after edge N when the FIFO was empty (1 cycle). Otherwise it queues in order.
- Output: the head is popped on out_valid && out_ready. out_pkt holds its value while out_valid && !out_ready. out_pkt=0 when empty.
- Simultaneous push and pop: occupancy is unchanged. When the FIFO is full, a pop frees space in the next cycle only (in_ready is registered).
- Read and write pointers wrap modulo DEPTH. Occupancy never exceeds DEPTH and never goes below 0.
- Counters saturate at all-ones and do not wrap. cnt_clr takes priority over a same-cycle increment; the result is 0.

Optional Feature:
- Macro OP_PKT_CHK_PARITY_EN.
- When defined:
  - Extra input port in_par (1 bit): even parity over in_pkt.
  - Check order: parity error first, then mode, then res. A parity error drops the packet with reason 11.
  - Adds a drop_par_cnt counter (CNT_WIDTH, same saturate/clear rules).
- When undefined: no in_par port, no drop_par_cnt counter, and reason 11 is never generated.

Decomposition:
- Package op_pkt_pkg holds:
  - PKT_W and the field offset/width localparams (RES_LSB, MODE_LSB).
  - Drop reason codes DROP_NONE, DROP_MODE, DROP_RES, DROP_PAR.
  - Default RES_MIN.
- One sub-module, op_pkt_fifo: synchronous show-ahead FIFO parametrised by WIDTH/DEPTH, exporting level/full/empty. The checker, counters and drop strobe stay in the top module.

Test Plan:
- Reset release then in_pkt={res=6, mode=0100, data=0xDEADBEEF}, out_ready=1 -> out_valid at the next cycle with the same packet; good_cnt=1.
- mode=0000, then mode=0110, res=9 -> two drop_pulse strobes with reason 01; drop_mode_cnt=2; no out_valid.
- res=5, mode=0001 -> drop reason 10, drop_res_cnt=1. Then res=0, mode=0011 -> reason 01 only; drop_res_cnt stays 1.
- out_ready=0, push 5 good packets with DEPTH=4 -> in_ready=0 after 4 are accepted, fifo_level=4. Assert out_ready -> packets drain in order, and the 5th is accepted one cycle after the first pop.
- CNT_WIDTH=2 with 5 good packets -> good_cnt saturates at 3. cnt_clr asserted in the same cycle as a good acceptance -> good_cnt=0.
- rst_n pulsed low with 3 packets queued -> out_valid=0, fifo_level=0 and counters 0 immediately (asynchronous). With OP_PKT_CHK_PARITY_EN, a bad-parity packet with valid fields -> reason 11, drop_par_cnt=1.
